// File: rtl/sram_arbiter_2m.sv
// Round-robin two-master arbiter for the 32-bit SRAM controller, one outstanding access at a time.
// Define SRAM_ARB_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYCLES and raise a sticky o_TIMEOUT.
module sram_arbiter_2m #(
   parameter int ADDR_W         = 18,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [ADDR_W-1:0]   i_m0_ADDR,
   input  logic [DATA_W-1:0]   i_m0_WDATA,
   input  logic [DATA_W/8-1:0] i_m0_BMASK,
   input  logic                i_m0_WREN,
   input  logic                i_m0_RDEN,
   output logic [DATA_W-1:0]   o_m0_RDATA,
   output logic                o_m0_ACK,
   input  logic [ADDR_W-1:0]   i_m1_ADDR,
   input  logic [DATA_W-1:0]   i_m1_WDATA,
   input  logic [DATA_W/8-1:0] i_m1_BMASK,
   input  logic                i_m1_WREN,
   input  logic                i_m1_RDEN,
   output logic [DATA_W-1:0]   o_m1_RDATA,
   output logic                o_m1_ACK,
   output logic [ADDR_W-1:0]   o_SRAM_ADDR,
   output logic [DATA_W-1:0]   o_SRAM_WDATA,
   output logic [DATA_W/8-1:0] o_SRAM_BMASK,
   output logic                o_SRAM_WREN,
   output logic                o_SRAM_RDEN,
   input  logic [DATA_W-1:0]   i_SRAM_RDATA,
   input  logic                i_SRAM_ACK,
   output logic                o_BUSY,
   output logic                o_TIMEOUT
);
   localparam int MASK_W = DATA_W / 8;
   localparam logic [DATA_W-1:0] TMO_DATA = DATA_W'(32'hDEADBEEF);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t              r_state;
   state_t              w_next;
   logic                w_req0;
   logic                w_req1;
   logic                w_pick;
   logic                w_grant_now;
   logic                w_done_now;
   logic                w_tmo_hit;
   logic [DATA_W-1:0]   w_rdata_in;
   logic                r_gnt;
   logic                r_last_grant;
   logic                r_op_wr;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [MASK_W-1:0]   r_bmask;
   logic [DATA_W-1:0]   r_m0_rdata;
   logic [DATA_W-1:0]   r_m1_rdata;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("sram_arbiter_2m: TIMEOUT_CYCLES must be at least 1");
   end

   assign w_req0      = i_m0_WREN | i_m0_RDEN;
   assign w_req1      = i_m1_WREN | i_m1_RDEN;
   // On contention the master that did not win last time goes first.
   assign w_pick      = (w_req0 & w_req1) ? ~r_last_grant : w_req1;
   assign w_grant_now = (r_state == S_IDLE) & (w_req0 | w_req1);
   assign w_done_now  = (r_state == S_WAIT) & (i_SRAM_ACK | w_tmo_hit);
   assign w_rdata_in  = i_SRAM_ACK ? i_SRAM_RDATA : TMO_DATA;

`ifdef SRAM_ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_timeout;

   // Cleared in ISSUE so the first WAIT cycle sees zero.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset)                r_wait_cnt <= '0;
      else if (r_state == S_ISSUE) r_wait_cnt <= '0;
      else if (r_state == S_WAIT)  r_wait_cnt <= r_wait_cnt + 1'b1;
   end

   assign w_tmo_hit = ~i_SRAM_ACK & (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset)                     r_timeout <= 1'b0;
      else if (w_done_now & w_tmo_hit)  r_timeout <= 1'b1;
   end

   assign o_TIMEOUT = r_timeout;
`else
   assign w_tmo_hit = 1'b0;
   assign o_TIMEOUT = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_req0 | w_req1) w_next = S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (w_done_now) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_SRAM_WREN = 1'b0;
      o_SRAM_RDEN = 1'b0;
      o_m0_ACK    = 1'b0;
      o_m1_ACK    = 1'b0;
      o_BUSY      = (r_state != S_IDLE);
      case (r_state)
         S_ISSUE: begin
            o_SRAM_WREN = r_op_wr;
            o_SRAM_RDEN = ~r_op_wr;
         end
         S_DONE: begin
            o_m0_ACK = ~r_gnt;
            o_m1_ACK = r_gnt;
         end
         default: ;
      endcase
   end

   // Write wins when a master raises WREN and RDEN together.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_gnt        <= 1'b0;
         r_last_grant <= 1'b1;
         r_op_wr      <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_bmask      <= '0;
         r_m0_rdata   <= '0;
         r_m1_rdata   <= '0;
      end else begin
         if (w_grant_now) begin
            r_gnt   <= w_pick;
            r_op_wr <= w_pick ? i_m1_WREN  : i_m0_WREN;
            r_addr  <= w_pick ? i_m1_ADDR  : i_m0_ADDR;
            r_wdata <= w_pick ? i_m1_WDATA : i_m0_WDATA;
            r_bmask <= w_pick ? i_m1_BMASK : i_m0_BMASK;
         end
         if (w_done_now) begin
            r_last_grant <= r_gnt;
            if (!r_op_wr) begin
               if (r_gnt) r_m1_rdata <= w_rdata_in;
               else       r_m0_rdata <= w_rdata_in;
            end
         end
      end
   end

   assign o_SRAM_ADDR  = r_addr;
   assign o_SRAM_WDATA = r_wdata;
   assign o_SRAM_BMASK = r_bmask;
   assign o_m0_RDATA   = r_m0_rdata;
   assign o_m1_RDATA   = r_m1_rdata;

endmodule

// File: tb/tb_sram_arbiter_2m.sv
// Bench for sram_arbiter_2m: behavioural SRAM controller responder plus a transaction-level
// round-robin model; SRAM_ARB_TIMEOUT_EN selects the timeout scenario.
`timescale 1ns/1ps
module tb_sram_arbiter_2m;
   localparam int AW = 18;
   localparam int DW = 32;

   typedef struct {
      int          cyc;
      bit          wr;
      bit          rd;
      logic [17:0] addr;
      logic [31:0] wdata;
      logic [3:0]  bmask;
   } stb_t;

   typedef struct {
      int          cyc;
      bit          m;
      logic [31:0] rdata;
      logic [31:0] other;
      bit          both;
   } ack_t;

   typedef struct {
      bit          m;
      bit          wr;
      logic [17:0] addr;
      logic [31:0] wdata;
      logic [3:0]  bmask;
      logic [31:0] rdata;
      logic [31:0] other;
   } txn_t;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic [3:0]    m0_bmask, m1_bmask;
   logic          m0_wren, m0_rden, m1_wren, m1_rden;
   logic [DW-1:0] o_m0_RDATA, o_m1_RDATA;
   logic          o_m0_ACK, o_m1_ACK;
   logic [AW-1:0] o_SRAM_ADDR;
   logic [DW-1:0] o_SRAM_WDATA;
   logic [3:0]    o_SRAM_BMASK;
   logic          o_SRAM_WREN, o_SRAM_RDEN;
   logic [DW-1:0] sram_rdata;
   logic          sram_ack;
   logic          o_BUSY, o_TIMEOUT;
   logic [123:0]  allout;

   int   nvec = 0;
   int   nerr = 0;
   int   cyc  = 0;
   stb_t stb_q[$];
   ack_t ack_q[$];
   txn_t exp_q[$];

   logic [31:0] ref_mem  [int];
   logic [31:0] sram_mem [int];
   logic [31:0] exp_rdata [2];
   bit          exp_last;

   int  dly_min, dly_max;
   bit  sram_hold;
   int  rem0, rem1;
   bit  tmo_flag;

   sram_arbiter_2m #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
      .i_clk(clk), .i_reset(rst_n),
      .i_m0_ADDR(m0_addr), .i_m0_WDATA(m0_wdata), .i_m0_BMASK(m0_bmask),
      .i_m0_WREN(m0_wren), .i_m0_RDEN(m0_rden), .o_m0_RDATA(o_m0_RDATA), .o_m0_ACK(o_m0_ACK),
      .i_m1_ADDR(m1_addr), .i_m1_WDATA(m1_wdata), .i_m1_BMASK(m1_bmask),
      .i_m1_WREN(m1_wren), .i_m1_RDEN(m1_rden), .o_m1_RDATA(o_m1_RDATA), .o_m1_ACK(o_m1_ACK),
      .o_SRAM_ADDR(o_SRAM_ADDR), .o_SRAM_WDATA(o_SRAM_WDATA), .o_SRAM_BMASK(o_SRAM_BMASK),
      .o_SRAM_WREN(o_SRAM_WREN), .o_SRAM_RDEN(o_SRAM_RDEN),
      .i_SRAM_RDATA(sram_rdata), .i_SRAM_ACK(sram_ack),
      .o_BUSY(o_BUSY), .o_TIMEOUT(o_TIMEOUT)
   );

   assign allout = {o_m0_RDATA, o_m0_ACK, o_m1_RDATA, o_m1_ACK, o_SRAM_ADDR, o_SRAM_WDATA,
                    o_SRAM_BMASK, o_SRAM_WREN, o_SRAM_RDEN, o_BUSY, o_TIMEOUT};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ref_rd(logic [17:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
   endfunction

   // Behavioural SRAM controller: ACKs each strobe after a random delay unless held off.
   initial begin : responder
      bit          pend;
      bit          pend_wr;
      int          pend_cnt;
      logic [17:0] pend_addr;
      sram_ack = 1'b0; sram_rdata = '0; pend = 0; pend_wr = 0; pend_cnt = 0; pend_addr = '0;
      forever begin
         @(negedge clk);
         sram_ack = 1'b0;
         if (!rst_n) pend = 0;
         else begin
            if (pend) begin
               if (pend_cnt == 0) begin
                  sram_ack   = 1'b1;
                  pend       = 0;
                  sram_rdata = pend_wr ? 32'($urandom)
                             : (sram_mem.exists(int'(pend_addr)) ? sram_mem[int'(pend_addr)] : 32'h0);
               end else pend_cnt--;
            end
            if (o_SRAM_WREN || o_SRAM_RDEN) begin
               pend      = !sram_hold;
               pend_wr   = o_SRAM_WREN;
               pend_addr = o_SRAM_ADDR;
               pend_cnt  = int'($urandom_range(dly_max, dly_min));
               if (o_SRAM_WREN)
                  sram_mem[int'(o_SRAM_ADDR)] = merge(sram_mem.exists(int'(o_SRAM_ADDR)) ?
                     sram_mem[int'(o_SRAM_ADDR)] : 32'h0, o_SRAM_WDATA, o_SRAM_BMASK);
            end
         end
      end
   end

   // Records strobes and acks; flags a second strobe before the previous one completed.
   initial begin : monitor
      bit outst;
      outst = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) outst = 0;
         if (o_SRAM_WREN || o_SRAM_RDEN) begin
            stb_q.push_back('{cyc, o_SRAM_WREN, o_SRAM_RDEN, o_SRAM_ADDR, o_SRAM_WDATA, o_SRAM_BMASK});
            nvec++;
            if (outst || (o_SRAM_WREN && o_SRAM_RDEN)) begin
               nerr++;
               $display("FAIL strobe_protocol: cycle %0d wren=%0b rden=%0b outstanding=%0b, required single strobe with none outstanding",
                        cyc, o_SRAM_WREN, o_SRAM_RDEN, outst);
            end
            outst = 1;
         end
         if (o_m0_ACK || o_m1_ACK) begin
            ack_q.push_back('{cyc, o_m1_ACK, o_m1_ACK ? o_m1_RDATA : o_m0_RDATA,
                              o_m1_ACK ? o_m0_RDATA : o_m1_RDATA, o_m0_ACK & o_m1_ACK});
            outst = 0;
         end
      end
   end

   // Transaction-level model: round robin over pending counts, write wins over read.
   function automatic void model_run(int n0, int n1);
      txn_t t;
      exp_q.delete();
      while (n0 > 0 || n1 > 0) begin
         if (n0 > 0 && n1 > 0) t.m = ~exp_last;
         else                  t.m = (n1 > 0);
         if (t.m) begin
            t.wr = m1_wren; t.addr = m1_addr; t.wdata = m1_wdata; t.bmask = m1_bmask; n1--;
         end else begin
            t.wr = m0_wren; t.addr = m0_addr; t.wdata = m0_wdata; t.bmask = m0_bmask; n0--;
         end
         if (t.wr) ref_mem[int'(t.addr)] = merge(ref_rd(t.addr), t.wdata, t.bmask);
         else      exp_rdata[t.m] = ref_rd(t.addr);
         t.rdata  = exp_rdata[t.m];
         t.other  = exp_rdata[!t.m];
         exp_last = t.m;
         exp_q.push_back(t);
      end
   endfunction

   task automatic clear_logs();
      stb_q.delete();
      ack_q.delete();
   endtask

   task automatic idle_masters();
      m0_wren = 0; m0_rden = 0; m1_wren = 0; m1_rden = 0;
   endtask

   // Holds requests until each master has collected rem0/rem1 ACKs, dropping at its last DONE.
   task automatic run(input int budget);
      int n;
      n = 0;
      tmo_flag = 0;
      while ((rem0 > 0 || rem1 > 0) && n < budget) begin
         @(negedge clk); #1; n++;
         if (o_m0_ACK && rem0 > 0) begin rem0--; if (rem0 == 0) begin m0_wren = 0; m0_rden = 0; end end
         if (o_m1_ACK && rem1 > 0) begin rem1--; if (rem1 == 0) begin m1_wren = 0; m1_rden = 0; end end
      end
      if (rem0 > 0 || rem1 > 0) tmo_flag = 1;
      rem0 = 0; rem1 = 0;
      idle_masters();
      @(negedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 0; idle_masters();
      m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; m0_bmask = '0; m1_bmask = '0;
      dly_min = 0; dly_max = 0; sram_hold = 0; rem0 = 0; rem1 = 0;
      exp_last = 1; exp_rdata[0] = '0; exp_rdata[1] = '0;
      repeat (2) begin @(negedge clk); #1; end
      nvec++;
      if (allout !== '0) begin nerr++; $display("FAIL reset_outputs: got %h required 0", allout); end
      rst_n = 1;
      repeat (2) begin @(negedge clk); #1; end
      nvec++;
      if (allout !== '0) begin nerr++; $display("FAIL post_reset_idle: got %h required 0", allout); end
   endtask

   task automatic test_m0_write();
      int t0;
      clear_logs(); idle_masters();
      dly_min = 2; dly_max = 2;
      m0_wren = 1; m0_addr = 18'h00010; m0_wdata = 32'h12345678; m0_bmask = 4'hF;
      model_run(1, 0);
      t0 = cyc; rem0 = 1; run(50);
      nvec++;
      if (tmo_flag) begin nerr++; $display("FAIL m0_write_done: no ACK within budget"); end
      nvec++;
      if (stb_q.size() != 1 || ack_q.size() != 1) begin
         nerr++; $display("FAIL m0_write_count: strobes %0d acks %0d required 1 1", stb_q.size(), ack_q.size());
      end else begin
         nvec++;
         if ({stb_q[0].wr, stb_q[0].rd, stb_q[0].addr, stb_q[0].wdata, stb_q[0].bmask} !==
             {1'b1, 1'b0, 18'h00010, 32'h12345678, 4'hF}) begin
            nerr++; $display("FAIL m0_write_fields: got wr=%0b rd=%0b a=%h d=%h m=%h required 1 0 00010 12345678 f",
                             stb_q[0].wr, stb_q[0].rd, stb_q[0].addr, stb_q[0].wdata, stb_q[0].bmask);
         end
         nvec++;
         if (stb_q[0].cyc != t0 + 1) begin
            nerr++; $display("FAIL m0_write_strobe_cycle: got %0d required %0d", stb_q[0].cyc, t0 + 1);
         end
         nvec++;
         if (ack_q[0].m !== 1'b0 || ack_q[0].both || ack_q[0].cyc != stb_q[0].cyc + 4) begin
            nerr++; $display("FAIL m0_write_ack: got master %0d both %0b cycle %0d required master 0 alone cycle %0d",
                             ack_q[0].m, ack_q[0].both, ack_q[0].cyc, stb_q[0].cyc + 4);
         end
      end
   endtask

   task automatic test_m1_read();
      clear_logs(); idle_masters();
      dly_min = 0; dly_max = 0;
      m1_rden = 1; m1_addr = 18'h00010; m1_wdata = 32'($urandom); m1_bmask = 4'($urandom);
      model_run(0, 1);
      rem1 = 1; run(50);
      nvec++;
      if (tmo_flag || stb_q.size() != 1 || ack_q.size() != 1) begin
         nerr++; $display("FAIL m1_read_count: strobes %0d acks %0d timeout %0b required 1 1 0",
                          stb_q.size(), ack_q.size(), tmo_flag);
      end else begin
         nvec++;
         if ({stb_q[0].wr, stb_q[0].rd, stb_q[0].addr} !== {1'b0, 1'b1, 18'h00010}) begin
            nerr++; $display("FAIL m1_read_strobe: got wr=%0b rd=%0b a=%h required 0 1 00010",
                             stb_q[0].wr, stb_q[0].rd, stb_q[0].addr);
         end
         nvec++;
         if (ack_q[0].m !== 1'b1 || ack_q[0].rdata !== 32'h12345678 || ack_q[0].cyc != stb_q[0].cyc + 2) begin
            nerr++; $display("FAIL m1_read_data: got master %0d data %h cycle %0d required 1 12345678 %0d",
                             ack_q[0].m, ack_q[0].rdata, ack_q[0].cyc, stb_q[0].cyc + 2);
         end
         nvec++;
         if (ack_q[0].other !== exp_rdata[0]) begin
            nerr++; $display("FAIL m1_read_m0_rdata: got %h required %h", ack_q[0].other, exp_rdata[0]);
         end
      end
   endtask

   task automatic test_simultaneous();
      clear_logs(); idle_masters();
      dly_min = 0; dly_max = 0;
      m0_rden = 1; m0_addr = 18'h1; m0_wdata = 32'($urandom); m0_bmask = 4'hF;
      m1_wren = 1; m1_addr = 18'h2; m1_wdata = 32'($urandom); m1_bmask = 4'($urandom);
      model_run(2, 2);
      rem0 = 2; rem1 = 2; run(100);
      nvec++;
      if (tmo_flag || stb_q.size() != 4 || ack_q.size() != 4) begin
         nerr++; $display("FAIL simul_count: strobes %0d acks %0d timeout %0b required 4 4 0",
                          stb_q.size(), ack_q.size(), tmo_flag);
      end else begin
         for (int i = 0; i < 4; i++) begin
            nvec++;
            if (ack_q[i].m !== exp_q[i].m || stb_q[i].addr !== exp_q[i].addr || ack_q[i].rdata !== exp_q[i].rdata) begin
               nerr++; $display("FAIL simul_order[%0d]: got master %0d addr %h data %h required %0d %h %h",
                                i, ack_q[i].m, stb_q[i].addr, ack_q[i].rdata, exp_q[i].m, exp_q[i].addr, exp_q[i].rdata);
            end
            if (i > 0) begin
               nvec++;
               if (stb_q[i].cyc - stb_q[i-1].cyc != 4 || stb_q[i].cyc <= ack_q[i-1].cyc) begin
                  nerr++; $display("FAIL simul_turnaround[%0d]: strobe gap %0d required 4", i, stb_q[i].cyc - stb_q[i-1].cyc);
               end
            end
         end
      end
   endtask

   task automatic test_wren_rden();
      clear_logs(); idle_masters();
      dly_min = 1; dly_max = 1;
      m0_wren = 1; m0_rden = 1; m0_addr = 18'h5; m0_wdata = 32'($urandom); m0_bmask = 4'hF;
      model_run(1, 0);
      rem0 = 1; run(50);
      nvec++;
      if (tmo_flag || stb_q.size() != 1 || ack_q.size() != 1) begin
         nerr++; $display("FAIL wr_rd_count: strobes %0d acks %0d required 1 1", stb_q.size(), ack_q.size());
      end else begin
         nvec++;
         if ({stb_q[0].wr, stb_q[0].rd, stb_q[0].addr, stb_q[0].wdata} !== {1'b1, 1'b0, 18'h5, m0_wdata}) begin
            nerr++; $display("FAIL wr_rd_strobe: got wr=%0b rd=%0b a=%h d=%h required 1 0 00005 %h",
                             stb_q[0].wr, stb_q[0].rd, stb_q[0].addr, stb_q[0].wdata, m0_wdata);
         end
         nvec++;
         if (ack_q[0].m !== 1'b0 || ack_q[0].rdata !== exp_q[0].rdata) begin
            nerr++; $display("FAIL wr_rd_rdata: got master %0d rdata %h required 0 %h", ack_q[0].m, ack_q[0].rdata, exp_q[0].rdata);
         end
      end
   endtask

   task automatic test_random();
      int n0, n1;
      for (int r = 0; r < 25; r++) begin
         clear_logs(); idle_masters();
         dly_min = 0; dly_max = 3;
         n0 = int'($urandom_range(3, 0));
         n1 = (n0 == 0) ? int'($urandom_range(3, 1)) : int'($urandom_range(3, 0));
         m0_addr = 18'($urandom_range(7, 0)); m0_wdata = 32'($urandom); m0_bmask = 4'($urandom);
         m1_addr = 18'($urandom_range(7, 0)); m1_wdata = 32'($urandom); m1_bmask = 4'($urandom);
         if (n0 > 0) begin m0_wren = 1'($urandom); m0_rden = m0_wren ? 1'($urandom) : 1'b1; end
         if (n1 > 0) begin m1_wren = 1'($urandom); m1_rden = m1_wren ? 1'($urandom) : 1'b1; end
         model_run(n0, n1);
         rem0 = n0; rem1 = n1; run(200);
         nvec++;
         if (tmo_flag || stb_q.size() != exp_q.size() || ack_q.size() != exp_q.size()) begin
            nerr++; $display("FAIL rnd_count: round %0d strobes %0d acks %0d timeout %0b required %0d",
                             r, stb_q.size(), ack_q.size(), tmo_flag, exp_q.size());
         end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
               nvec++;
               if ({stb_q[i].wr, stb_q[i].rd, stb_q[i].addr, stb_q[i].wdata, stb_q[i].bmask} !==
                   {exp_q[i].wr, !exp_q[i].wr, exp_q[i].addr, exp_q[i].wdata, exp_q[i].bmask}) begin
                  nerr++; $display("FAIL rnd_strobe[%0d.%0d]: got wr=%0b a=%h d=%h m=%h required wr=%0b a=%h d=%h m=%h",
                                   r, i, stb_q[i].wr, stb_q[i].addr, stb_q[i].wdata, stb_q[i].bmask,
                                   exp_q[i].wr, exp_q[i].addr, exp_q[i].wdata, exp_q[i].bmask);
               end
               nvec++;
               if ({ack_q[i].m, ack_q[i].both, ack_q[i].rdata, ack_q[i].other} !==
                   {exp_q[i].m, 1'b0, exp_q[i].rdata, exp_q[i].other}) begin
                  nerr++; $display("FAIL rnd_ack[%0d.%0d]: got master %0d both %0b data %h other %h required %0d 0 %h %h",
                                   r, i, ack_q[i].m, ack_q[i].both, ack_q[i].rdata, ack_q[i].other,
                                   exp_q[i].m, exp_q[i].rdata, exp_q[i].other);
               end
            end
         end
      end
      nvec++;
      if ({o_m0_RDATA, o_m1_RDATA} !== {exp_rdata[0], exp_rdata[1]}) begin
         nerr++; $display("FAIL rdata_hold: got %h %h required %h %h", o_m0_RDATA, o_m1_RDATA, exp_rdata[0], exp_rdata[1]);
      end
   endtask

   task automatic test_reset_mid_wait();
      clear_logs(); idle_masters();
      sram_hold = 1;
      m0_rden = 1; m0_addr = 18'h3;
      repeat (3) begin @(negedge clk); #1; end
      nvec++;
      if (o_BUSY !== 1'b1 || stb_q.size() != 1) begin
         nerr++; $display("FAIL rst_wait_setup: busy %0b strobes %0d required 1 1", o_BUSY, stb_q.size());
      end
      rst_n = 0; #1;
      nvec++;
      if (allout !== '0) begin nerr++; $display("FAIL rst_async_outputs: got %h required 0", allout); end
      idle_masters();
      repeat (3) begin @(negedge clk); #1; end
      rst_n = 1; sram_hold = 0;
      exp_last = 1; exp_rdata[0] = '0; exp_rdata[1] = '0;
      repeat (2) begin @(negedge clk); #1; end
      nvec++;
      if (ack_q.size() != 0) begin nerr++; $display("FAIL rst_no_ack: got %0d acks required 0", ack_q.size()); end
      clear_logs();
      dly_min = 0; dly_max = 0;
      m1_rden = 1; m1_addr = 18'h00010;
      model_run(0, 1);
      rem1 = 1; run(50);
      nvec++;
      if (tmo_flag || stb_q.size() != 1 || ack_q.size() != 1) begin
         nerr++; $display("FAIL rst_m1_count: strobes %0d acks %0d required 1 1", stb_q.size(), ack_q.size());
      end else begin
         nvec++;
         if (ack_q[0].m !== 1'b1 || stb_q[0].addr !== 18'h00010 || ack_q[0].rdata !== exp_q[0].rdata) begin
            nerr++; $display("FAIL rst_m1_grant: got master %0d addr %h data %h required 1 00010 %h",
                             ack_q[0].m, stb_q[0].addr, ack_q[0].rdata, exp_q[0].rdata);
         end
      end
   endtask

`ifdef SRAM_ARB_TIMEOUT_EN
   task automatic test_timeout();
      clear_logs(); idle_masters();
      sram_hold = 1;
      m0_rden = 1; m0_addr = 18'h4;
      rem0 = 1; run(60);
      sram_hold = 0;
      nvec++;
      if (tmo_flag || stb_q.size() != 1 || ack_q.size() != 1) begin
         nerr++; $display("FAIL tmo_count: strobes %0d acks %0d timeout %0b required 1 1 0", stb_q.size(), ack_q.size(), tmo_flag);
      end else begin
         nvec++;
         if (ack_q[0].m !== 1'b0 || ack_q[0].rdata !== 32'hDEADBEEF || ack_q[0].cyc - stb_q[0].cyc != 9) begin
            nerr++; $display("FAIL tmo_ack: got master %0d data %h delay %0d required 0 deadbeef 9",
                             ack_q[0].m, ack_q[0].rdata, ack_q[0].cyc - stb_q[0].cyc);
         end
      end
      nvec++;
      if (o_TIMEOUT !== 1'b1 || o_BUSY !== 1'b0) begin
         nerr++; $display("FAIL tmo_flag: got timeout %0b busy %0b required 1 0", o_TIMEOUT, o_BUSY);
      end
      repeat (5) begin @(negedge clk); #1; end
      nvec++;
      if (o_TIMEOUT !== 1'b1) begin nerr++; $display("FAIL tmo_sticky: got %0b required 1", o_TIMEOUT); end
   endtask
`else
   task automatic test_no_timeout();
      clear_logs(); idle_masters();
      sram_hold = 1;
      m0_rden = 1; m0_addr = 18'h4;
      repeat (40) begin @(negedge clk); #1; end
      nvec++;
      if (ack_q.size() != 0 || o_BUSY !== 1'b1 || o_TIMEOUT !== 1'b0) begin
         nerr++; $display("FAIL wait_forever: acks %0d busy %0b timeout %0b required 0 1 0", ack_q.size(), o_BUSY, o_TIMEOUT);
      end
      idle_masters();
      rst_n = 0;
      repeat (2) begin @(negedge clk); #1; end
      rst_n = 1; sram_hold = 0;
      exp_last = 1; exp_rdata[0] = '0; exp_rdata[1] = '0;
      repeat (2) begin @(negedge clk); #1; end
   endtask
`endif

   initial begin
      test_reset();
      test_m0_write();
      test_m1_read();
      test_simultaneous();
      test_wren_rden();
      test_random();
      test_reset_mid_wait();
`ifdef SRAM_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/sram_arbiter_2m.md
Name: sram_arbiter_2m

Overview:
- Two-master arbiter in front of the 32-bit SRAM controller (`sram_IS61WV25616_controller_32b_5lr`).
- Master 0 is instruction fetch and master 1 is the load/store unit.
- Shares the single controller port between them with round-robin fairness and one outstanding transaction at a time.
- Latches the winning request, issues a one-cycle RDEN/WREN strobe to the controller, waits for its ACK, then routes RDATA/ACK back to the granted master.

Parameters:
- ADDR_W, 18, SRAM word address width.
- DATA_W, 32, data width; BMASK width is DATA_W/8.
- TIMEOUT_CYCLES, 255, WAIT-state cycle limit; used only with the optional feature.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous active-low reset.
- i_m0_ADDR  in  ADDR_W  master 0 address.
- i_m0_WDATA  in  DATA_W  master 0 write data.
- i_m0_BMASK  in  4  master 0 byte mask.
- i_m0_WREN  in  1  master 0 write request, level-held.
- i_m0_RDEN  in  1  master 0 read request, level-held.
- o_m0_RDATA  out  DATA_W  read data to master 0.
- o_m0_ACK  out  1  one-cycle completion pulse to master 0.
- i_m1_ADDR, i_m1_WDATA, i_m1_BMASK, i_m1_WREN, i_m1_RDEN, o_m1_RDATA, o_m1_ACK: identical set for master 1.
- o_SRAM_ADDR  out  ADDR_W  to controller i_ADDR.
- o_SRAM_WDATA  out  DATA_W  to controller i_WDATA.
- o_SRAM_BMASK  out  4  to controller i_BMASK.
- o_SRAM_WREN  out  1  to controller i_WREN.
- o_SRAM_RDEN  out  1  to controller i_RDEN.
- i_SRAM_RDATA  in  DATA_W  from controller o_RDATA.
- i_SRAM_ACK  in  1  from controller o_ACK.
- o_BUSY  out  1  high in any state other than IDLE.
- o_TIMEOUT  out  1  sticky timeout flag.

Behaviour:
- **Reset:**
  - i_reset=0 forces state IDLE.
  - Drives 0 on all outputs, including o_mX_RDATA, o_SRAM_* and o_TIMEOUT.
  - Sets last_grant=1, so master 0 wins first.
  - Reset mid-transaction abandons it; no ACK is returned.
- **Request definition:** reqX = i_mX_WREN | i_mX_RDEN. Masters hold the request and its fields stable until they see o_mX_ACK.
- **FSM, state IDLE:**
  - If no request, stay in IDLE.
  - If only one master requests, grant it.
  - If both request, grant the master != last_grant.
  - On grant, register ADDR, WDATA, BMASK and op. Op is write if WREN=1, even when RDEN=1 as well.
  - Set gnt, then go to ISSUE.
- **FSM, state ISSUE:**
  - o_SRAM_ADDR, WDATA and BMASK come from the latched registers and stay stable through ISSUE and WAIT.
  - Exactly one of o_SRAM_WREN or o_SRAM_RDEN is high, for this single cycle.
  - Next state is WAIT.
- **FSM, state WAIT:**
  - Strobes are low.
  - On i_SRAM_ACK=1: capture i_SRAM_RDATA into o_mgnt_RDATA (reads only; writes leave RDATA unchanged), set o_mgnt_ACK=1, set last_grant=gnt, go to DONE.
- **FSM, state DONE:**
  - o_mgnt_ACK is high for this one cycle only; the other master's ACK stays 0.
  - Next state is IDLE.
  - DONE exists so that the master's still-high request is not re-sampled.
- **Timing:**
  - Request seen at edge N gives the strobe in cycle N+1.
  - Controller ACK at edge M gives the master ACK in cycle M+1.
  - Minimum turnaround is 4 cycles when the controller ACKs one cycle after the strobe.
- **Held request:** a request held through DONE is re-arbitrated in IDLE as a new transaction. A master must drop its request at the edge ending DONE unless it wants another access.
- **Don't-care inputs:** i_SRAM_ACK outside WAIT is ignored. Master field changes while not granted are ignored.
- o_mX_RDATA holds its last value until the next read completion for that master.

Optional Feature:
- Macro: SRAM_ARB_TIMEOUT_EN.
- **With the macro defined:**
  - An 8-bit+ counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without i_SRAM_ACK, go to DONE.
  - Pulse o_mgnt_ACK, load o_mgnt_RDATA=32'hDEADBEEF for reads, and set o_TIMEOUT=1 (sticky until reset).
  - last_grant updates normally.
- **Without the macro:** WAIT waits indefinitely, no counter is synthesized, and o_TIMEOUT is tied 0.

Test Plan:
- **Master-0 write:** m0 WREN, ADDR=18'h00010, WDATA=32'h12345678, BMASK=4'b1111.
  - Expect o_SRAM_WREN high for exactly 1 cycle with those values.
  - Controller ACK at cycle M, then o_m0_ACK pulses 1 cycle at M+1 and o_m1_ACK stays 0.
- **Master-1 read:** m1 RDEN at 18'h00010 after the write, using a behavioural SRAM model.
  - Expect o_SRAM_RDEN for 1 cycle, o_m1_RDATA=32'h12345678 with o_m1_ACK, and o_m0_RDATA unchanged.
- **Simultaneous requests:** m0 reads 18'h1, m1 writes 18'h2, both held continuously for 4 transactions.
  - Grant order must be m0, m1, m0, m1.
  - o_SRAM_ADDR alternates 18'h1 / 18'h2, never two strobes without an intervening ACK.
- **WREN+RDEN together:** m0 asserts both with ADDR=18'h5.
  - Expect o_SRAM_WREN=1, o_SRAM_RDEN=0, and o_m0_RDATA unchanged.
- **Reset mid-WAIT:** i_reset=0 while in WAIT (ACK withheld).
  - All outputs go 0 asynchronously and no o_mX_ACK is produced.
  - After release, the first request from m1 alone is granted.
- **Timeout (SRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8):** m0 read with controller ACK never asserted.
  - Expect o_m0_ACK about 9 cycles after the strobe, o_m0_RDATA=32'hDEADBEEF, o_TIMEOUT=1 and held, o_BUSY returns 0.
